fetch_unit: RTL

Instruction fetch stage for the rv32i core. It owns the program counter, issues word-aligned read requests to instruction memory, and buffers in-order responses in a small FIFO. It presents each instruction to the decode stage over a valid/ready handshake, together with the instruction's PC. A branch/jump redirect from execute flushes the buffer and discards in-flight responses.

---
 rtl/fetch_unit.sv | 105 ++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word-aligned reads and buffers in-order
// responses in a small FIFO presented to decode with the instruction's PC.
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rstn,
  output logic [XLEN-1:0] o_im_araddr,
  output logic            o_im_arvalid,
  input  logic            i_im_arready,
  input  logic            i_im_rvalid,
  input  logic [XLEN-1:0] i_im_rdata,
  output logic            o_im_rready,
  output logic            o_if_valid,
  output logic [XLEN-1:0] o_if_inst,
  output logic [XLEN-1:0] o_if_pc,
  input  logic            i_id_ready,
  input  logic            i_br_valid,
  input  logic [XLEN-1:0] i_br_target
);

  localparam int unsigned PW      = $clog2(DEPTH);
  localparam int unsigned CW      = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_out_cnt;
  logic [CW-1:0]   r_kill_cnt;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [XLEN-1:0] r_inst_mem [DEPTH];
  logic [XLEN-1:0] r_pc_mem   [DEPTH];

  logic            w_req;
  logic            w_rsp;
  logic            w_push;
  logic            w_pop;
  logic [CW:0]     w_pending;
  logic [XLEN-1:0] w_br_addr;

  // Slots are reserved at issue, so in-flight plus buffered never exceeds DEPTH.
  assign w_pending = {1'b0, r_out_cnt} + {1'b0, r_count};
  assign w_br_addr = {i_br_target[XLEN-1:2], 2'b00};

  assign o_im_araddr  = r_pc;
  assign o_im_rready  = 1'b1;
  assign o_im_arvalid = rstn && !i_br_valid && (w_pending < DEPTH_W);
  assign o_if_valid   = (r_count != '0) && !i_br_valid;
  assign o_if_inst    = r_inst_mem[r_rptr];
  assign o_if_pc      = r_pc_mem[r_rptr];

  // A response with nothing outstanding is a protocol violation and is ignored.
  assign w_req  = o_im_arvalid && i_im_arready;
  assign w_rsp  = i_im_rvalid && (r_out_cnt != '0);
  assign w_push = w_rsp && (r_kill_cnt == '0) && !i_br_valid;
  assign w_pop  = o_if_valid && i_id_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc       <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_out_cnt  <= '0;
      r_kill_cnt <= '0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_inst_mem[i] <= '0;
        r_pc_mem[i]   <= '0;
      end
    end else begin
      r_out_cnt <= r_out_cnt + CW'(w_req) - CW'(w_rsp);
      if (i_br_valid) begin
        // Everything still in flight after this cycle belongs to the old path.
        r_pc       <= w_br_addr;
        r_rsp_pc   <= w_br_addr;
        r_count    <= '0;
        r_rptr     <= r_wptr;
        r_kill_cnt <= r_out_cnt - CW'(w_rsp);
      end else begin
        if (w_req) begin
          r_pc <= r_pc + XLEN'(4);
        end
        if (w_push) begin
          r_inst_mem[r_wptr] <= i_im_rdata;
          r_pc_mem[r_wptr]   <= r_rsp_pc;
          r_wptr             <= r_wptr + PW'(1);
          r_rsp_pc           <= r_rsp_pc + XLEN'(4);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + PW'(1);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
        if (w_rsp && (r_kill_cnt != '0)) begin
          r_kill_cnt <= r_kill_cnt - CW'(1);
        end
      end
    end
  end

endmodule
